// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the activation stage and its inverse solver.
// Q.5 constants, solver states and the sigmoid step thresholds.
package nn_fixed_pkg;

   localparam logic [7:0]        Q5_ONE    = 8'h20;
   localparam logic [7:0]        Q5_HALF   = 8'h10;
   localparam logic signed [8:0] X_MIN     = -9'sd128;
   localparam logic signed [8:0] X_MAX_SAT = 9'sd128;

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   // Entry k-1 is the smallest Q2.5 input whose truncated Q.5 sigmoid reaches k.
   localparam logic signed [7:0] SIG_THRESH [31] = '{
      -8'sd109, -8'sd86, -8'sd72, -8'sd62, -8'sd53, -8'sd46, -8'sd40, -8'sd35,
      -8'sd30,  -8'sd25, -8'sd20, -8'sd16, -8'sd12, -8'sd8,  -8'sd4,  8'sd0,
      8'sd5,    8'sd9,   8'sd13,  8'sd17,  8'sd21,  8'sd26,  8'sd31,  8'sd36,
      8'sd41,   8'sd47,  8'sd54,  8'sd63,  8'sd73,  8'sd87,  8'sd110
   };

endpackage

// File: rtl/logit_q5_solver_if.sv
// Request/response handshake bundle for the logit solver.
interface logit_q5_solver_if #(
   parameter int OUT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       y_in;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] x_out;
   logic             sat;

   modport master (
      output in_valid, y_in, out_ready,
      input  in_ready, out_valid, x_out, sat
   );

   modport slave (
      input  in_valid, y_in, out_ready,
      output in_ready, out_valid, x_out, sat
   );
endinterface

// File: rtl/sigmoid_q5_rom.sv
// Forward sigmoid table: signed Q2.5 in, unsigned Q.5 out (truncated).
// The output is the number of step thresholds the input has reached, so it is monotonic.
module sigmoid_q5_rom
   import nn_fixed_pkg::*;
(
   input  logic signed [7:0] x,
   output logic [7:0]        f
);

   always_comb begin
      f = '0;
      for (int k = 0; k < 31; k++) begin
         if (x >= SIG_THRESH[k]) begin
            f = f + 8'd1;
         end
      end
   end

endmodule

// File: rtl/logit_q5_solver.sv
// Inverse sigmoid: binary-searches the forward table for the smallest x with sig(x) >= y.
// One request in flight; eight search steps per unsaturated request.
module logit_q5_solver
   import nn_fixed_pkg::*;
#(
   parameter int OUT_W     = 16,
   parameter int FRAC_BITS = 5
) (
   input logic               clk,
   input logic               rst,
   logit_q5_solver_if.slave  bus
);

   if (OUT_W < 9 || FRAC_BITS != 5) begin : g_param_check
      $error("logit_q5_solver: OUT_W must be >= 9 and FRAC_BITS must be 5");
   end

   state_t            state_q, state_d;
   logic [7:0]        y_q, y_d;
   logic [8:0]        lo_q, lo_d;
   logic [8:0]        hi_q, hi_d;
   logic [2:0]        cnt_q, cnt_d;
   logic signed [8:0] x_q, x_d;
   logic              sat_q, sat_d;

   logic [8:0]        mid;
   logic signed [7:0] rom_x;
   logic [7:0]        f;

   // lo and hi are offset indices (x + 128), so flipping the MSB recovers the signed input.
   assign mid   = 9'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
   assign rom_x = mid[7:0] ^ 8'h80;

   sigmoid_q5_rom u_rom (
      .x (rom_x),
      .f (f)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         y_q     <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         cnt_q   <= '0;
         x_q     <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         sat_q   <= sat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      sat_d   = sat_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               y_d = bus.y_in;
               if (bus.y_in == 8'h00) begin
                  x_d     = X_MIN;
                  sat_d   = 1'b1;
                  state_d = DONE;
               end else if (bus.y_in >= Q5_ONE) begin
                  x_d     = X_MAX_SAT;
                  sat_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  lo_d    = 9'd0;
                  hi_d    = 9'd255;
                  cnt_d   = 3'd0;
                  state_d = SEARCH;
               end
            end
         end

         SEARCH: begin
            if (f >= y_q) begin
               hi_d = mid;
            end else begin
               lo_d = mid + 9'd1;
            end
            cnt_d = cnt_q + 3'd1;
            // The interval has shrunk to a single index after the eighth step.
            if (cnt_q == 3'd7) begin
               x_d     = lo_d - 9'd128;
               sat_d   = 1'b0;
               state_d = DONE;
            end
         end

         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.x_out     = OUT_W'(x_q);
   assign bus.sat       = sat_q;

endmodule

// File: tb/tb_logit_q5_solver.sv
// Directed bench for logit_q5_solver: reset, searched and saturated results,
// backpressure, mid-search reset and a full sweep against a real-valued sigmoid model.
module tb_logit_q5_solver;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   logit_q5_solver_if #(.OUT_W(16)) bus ();

   logit_q5_solver #(.OUT_W(16), .FRAC_BITS(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Smallest x in [-128,127] with floor(32*sigmoid(x/32)) >= y, straight from the math.
   function automatic int model_x(input int y);
      real s;
      for (int x = -128; x <= 127; x++) begin
         s = 32.0 / (1.0 + $exp(-real'(x) / 32.0));
         if (int'($floor(s)) >= y) return x;
      end
      return 128;
   endfunction

   // Presents a request and returns at the negedge just after the accepting edge.
   task automatic start_req(input logic [7:0] y);
      int w = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.y_in     = y;
      while (!bus.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL accept_timeout y=%h in_ready=%b required 1", y, bus.in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Counts negedges after the accept edge until out_valid is seen (1 = first negedge).
   task automatic wait_out(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_out(input int delay);
      repeat (delay) @(negedge clk);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.y_in      = 8'h00;
      rst           = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b want=1", bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      checks++;
      if (bus.x_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_x_out got=%h want=0000", bus.x_out); end
      checks++;
      if (bus.sat !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat got=%b want=0", bus.sat); end
   endtask

   task automatic test_search();
      logic [7:0]  ys [5] = '{8'h10, 8'h18, 8'h08, 8'h1F, 8'h01};
      logic [15:0] xs [5] = '{16'h0000, 16'h0024, 16'hFFDD, 16'h006E, 16'hFF93};
      int lat;
      for (int i = 0; i < 5; i++) begin
         start_req(ys[i]);
         wait_out(lat);
         checks++;
         if (lat != 9) begin errors++; $display("[TB] FAIL search_latency y=%h got=%0d want=9", ys[i], lat); end
         checks++;
         if (bus.x_out !== xs[i]) begin errors++; $display("[TB] FAIL search_x y=%h got=%h want=%h", ys[i], bus.x_out, xs[i]); end
         checks++;
         if (bus.sat !== 1'b0) begin errors++; $display("[TB] FAIL search_sat y=%h got=%b want=0", ys[i], bus.sat); end
         release_out(0);
      end
   endtask

   task automatic test_saturate();
      logic [7:0]  ys [3] = '{8'h00, 8'h20, 8'hFF};
      logic [15:0] xs [3] = '{16'hFF80, 16'h0080, 16'h0080};
      int lat;
      for (int i = 0; i < 3; i++) begin
         start_req(ys[i]);
         wait_out(lat);
         checks++;
         if (lat != 1) begin errors++; $display("[TB] FAIL sat_latency y=%h got=%0d want=1", ys[i], lat); end
         checks++;
         if (bus.x_out !== xs[i]) begin errors++; $display("[TB] FAIL sat_x y=%h got=%h want=%h", ys[i], bus.x_out, xs[i]); end
         checks++;
         if (bus.sat !== 1'b1) begin errors++; $display("[TB] FAIL sat_flag y=%h got=%b want=1", ys[i], bus.sat); end
         checks++;
         if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL sat_in_ready y=%h got=%b want=0", ys[i], bus.in_ready); end
         release_out(1);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      start_req(8'h18);
      wait_out(lat);
      // A competing request waits while the result is stalled.
      bus.in_valid = 1'b1;
      bus.y_in     = 8'h08;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.x_out !== 16'h0024 || bus.sat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold cycle=%0d got=%h/%b want=0024/0", i, bus.x_out, bus.sat);
         end
         checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_flags cycle=%0d in_ready=%b out_valid=%b want 0/1", i, bus.in_ready, bus.out_valid);
         end
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_after_handshake in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_out(lat);
      checks++;
      if (lat != 9) begin errors++; $display("[TB] FAIL bp_second_latency got=%0d want=9", lat); end
      checks++;
      if (bus.x_out !== 16'hFFDD) begin errors++; $display("[TB] FAIL bp_second_x got=%h want=FFDD", bus.x_out); end
      release_out(0);
   endtask

   task automatic test_reset_mid_search();
      int lat;
      start_req(8'h18);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready got=%b want=1", bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid got=%b want=0", bus.out_valid); end
      checks++;
      if (bus.x_out !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_x_out got=%h want=0000", bus.x_out); end
      start_req(8'h01);
      wait_out(lat);
      checks++;
      if (lat != 9) begin errors++; $display("[TB] FAIL midrst_next_latency got=%0d want=9", lat); end
      checks++;
      if (bus.x_out !== 16'hFF93 || bus.sat !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_next_x got=%h/%b want=FF93/0", bus.x_out, bus.sat);
      end
      release_out(0);
   endtask

   task automatic test_sweep();
      int          lat;
      logic [15:0] want;
      for (int y = 1; y <= 31; y++) begin
         want = 16'(model_x(y));
         start_req(8'(y));
         wait_out(lat);
         checks++;
         if (bus.x_out !== want || bus.sat !== 1'b0 || lat != 9) begin
            errors++;
            $display("[TB] FAIL sweep y=%h got=%h/%b lat=%0d want=%h/0 lat=9", y[7:0], bus.x_out, bus.sat, lat, want);
         end
         release_out(int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.y_in      = 8'h00;
      test_reset();
      test_search();
      test_saturate();
      test_back_to_back();
      test_reset_mid_search();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
